// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg: LEGv8 opcodes, ALU encodings, FSM states and the decoded-control struct
package control_sequencer_pkg;
  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
  localparam logic [10:0] OP_ADDS  = 11'b10101011000;
  localparam logic [10:0] OP_SUBS  = 11'b11101011000;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [3:0]  COND_LT  = 4'b1011;
  localparam logic [2:0]  ALU_PASS = 3'b000;
  localparam logic [2:0]  ALU_ADD  = 3'b010;
  localparam logic [2:0]  ALU_SUB  = 3'b011;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  typedef enum logic [2:0] {K_NOP, K_ALU, K_LD, K_ST, K_B, K_CBZ, K_BCOND} kind_t;
  typedef struct packed {
    kind_t      kind;
    logic       reg2loc;
    logic       alusrc;
    logic [2:0] aluop;
    logic       setflags;
    logic       cond_lt;
    logic       mem2reg;
  } ctrl_t;
endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: datapath/memory handshake bundle between the sequencer (slave) and the datapath (master)
interface control_sequencer_if;
  logic [31:0] instr;
  logic        alu_zero;
  logic        flag_n;
  logic        flag_v;
  logic        mem_ready;
  logic        ir_we;
  logic        pc_we;
  logic        uncondbr;
  logic        br_taken;
  logic        reg2loc;
  logic        alusrc;
  logic [2:0]  aluop;
  logic        flag_we;
  logic        mem_req;
  logic        mem_we;
  logic        mem2reg;
  logic        reg_we;
  logic        halted;
  logic        mem_err;
  modport master (
    output instr, alu_zero, flag_n, flag_v, mem_ready,
    input  ir_we, pc_we, uncondbr, br_taken, reg2loc, alusrc, aluop,
           flag_we, mem_req, mem_we, mem2reg, reg_we, halted, mem_err
  );
  modport slave (
    input  instr, alu_zero, flag_n, flag_v, mem_ready,
    output ir_we, pc_we, uncondbr, br_taken, reg2loc, alusrc, aluop,
           flag_we, mem_req, mem_we, mem2reg, reg_we, halted, mem_err
  );
endinterface

// File: rtl/control_sequencer_decoder.sv
// instr_decoder: combinational opcode match to ctrl_t; illegal_o flags an unrecognised opcode
module instr_decoder
  import control_sequencer_pkg::*;
(
  input  logic [10:0] op_i,
  input  logic [3:0]  cond_i,
  output ctrl_t       ctrl_o,
  output logic        illegal_o
);
  always_comb begin
    ctrl_o = '0;
    illegal_o = 1'b0;
    if (op_i[10:5] == OP_B) ctrl_o.kind = K_B;
    else if (op_i[10:3] == OP_CBZ) begin
      ctrl_o.kind = K_CBZ;
      ctrl_o.reg2loc = 1'b1;
    end else if (op_i[10:3] == OP_BCOND) begin
      ctrl_o.kind = K_BCOND;
      ctrl_o.cond_lt = cond_i == COND_LT;
    end else if (op_i[10:1] == OP_ADDI) begin
      ctrl_o.kind = K_ALU;
      ctrl_o.alusrc = 1'b1;
      ctrl_o.aluop = ALU_ADD;
    end else if (op_i == OP_ADDS || op_i == OP_SUBS) begin
      ctrl_o.kind = K_ALU;
      ctrl_o.aluop = op_i == OP_SUBS ? ALU_SUB : ALU_ADD;
      ctrl_o.setflags = 1'b1;
    end else if (op_i == OP_LDUR || op_i == OP_STUR) begin
      ctrl_o.kind = op_i == OP_LDUR ? K_LD : K_ST;
      ctrl_o.alusrc = 1'b1;
      ctrl_o.aluop = ALU_ADD;
      ctrl_o.mem2reg = op_i == OP_LDUR;
      ctrl_o.reg2loc = op_i == OP_STUR;
    end else illegal_o = 1'b1;
  end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle LEGv8 control FSM; define ILLEGAL_TRAP_EN to halt on undecoded opcodes
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 5
) (
  input logic clk,
  input logic reset,
  control_sequencer_if.slave bus
);
  state_t state_q, state_d;
  ctrl_t ctrl_q, ctrl_d, dec_ctrl;
  logic [14:0] ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic err_q, err_d, dec_illegal, dp;
  instr_decoder u_dec (
    .op_i(ir_q[14:4]),
    .cond_i(ir_q[3:0]),
    .ctrl_o(dec_ctrl),
    .illegal_o(dec_illegal)
  );
  // datapath selects are only meaningful once decode fields are registered
  assign dp = state_q inside {S_EXEC, S_MEM, S_WB};
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      ir_q <= '0;
      ctrl_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q <= ir_d;
      ctrl_q <= ctrl_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    ir_d = ir_q;
    ctrl_d = ctrl_q;
    cnt_d = '0;
    err_d = err_q;
    bus.ir_we = 1'b0;
    bus.pc_we = 1'b0;
    bus.uncondbr = 1'b0;
    bus.br_taken = 1'b0;
    bus.reg2loc = 1'b0;
    bus.alusrc = 1'b0;
    bus.aluop = ALU_PASS;
    bus.flag_we = 1'b0;
    bus.mem_req = 1'b0;
    bus.mem_we = 1'b0;
    bus.mem2reg = 1'b0;
    bus.reg_we = 1'b0;
    bus.halted = 1'b0;
    bus.mem_err = 1'b0;
    if (reset) begin
      bus.reg2loc = dp & ctrl_q.reg2loc;
      bus.alusrc = dp & ctrl_q.alusrc;
      bus.aluop = dp ? ctrl_q.aluop : ALU_PASS;
      bus.uncondbr = dp & (ctrl_q.kind == K_B);
      bus.halted = state_q == S_HALT;
      bus.mem_err = err_q;
      case (state_q)
        S_FETCH: begin
          bus.ir_we = 1'b1;
          ir_d = {bus.instr[31:21], bus.instr[3:0]};
          state_d = S_DECODE;
        end
        S_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
          ctrl_d = dec_ctrl;
          state_d = dec_illegal ? S_HALT : S_EXEC;
`else
          ctrl_d = dec_illegal ? ctrl_t'('0) : dec_ctrl;
          state_d = S_EXEC;
`endif
        end
        S_EXEC: begin
          bus.flag_we = ctrl_q.setflags;
          if (ctrl_q.kind == K_ALU) state_d = S_WB;
          else if (ctrl_q.kind == K_LD || ctrl_q.kind == K_ST) state_d = S_MEM;
          else begin
            bus.pc_we = 1'b1;
            bus.br_taken = (ctrl_q.kind == K_B)
                         | (ctrl_q.kind == K_CBZ & bus.alu_zero)
                         | (ctrl_q.kind == K_BCOND & ctrl_q.cond_lt & (bus.flag_n ^ bus.flag_v));
            state_d = S_FETCH;
          end
        end
        S_MEM: begin
          bus.mem_req = 1'b1;
          bus.mem_we = ctrl_q.kind == K_ST;
          if (bus.mem_ready) begin
            bus.pc_we = ctrl_q.kind == K_ST;
            state_d = ctrl_q.kind == K_LD ? S_WB : S_FETCH;
          end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
            err_d = 1'b1;
            state_d = S_HALT;
          end else cnt_d = cnt_q + 1'b1;
        end
        S_WB: begin
          bus.reg_we = 1'b1;
          bus.pc_we = 1'b1;
          bus.mem2reg = ctrl_q.mem2reg;
          state_d = S_FETCH;
        end
        default: state_d = state_q;
      endcase
    end
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed steps with a scoreboard of per-cycle expected control vectors
module tb_control_sequencer;
  localparam logic [15:0] IR = 16'h8000, PC = 16'h4000, UB = 16'h2000, BT = 16'h1000;
  localparam logic [15:0] R2 = 16'h0800, AS = 16'h0400, ADD = 16'h0100, SUB = 16'h0180;
  localparam logic [15:0] FW = 16'h0040, MR = 16'h0020, MW = 16'h0010, M2R = 16'h0008;
  localparam logic [15:0] RW = 16'h0004, HT = 16'h0002, ME = 16'h0001;
  typedef struct {
    string tag;
    logic [15:0] exp;
  } sb_t;
  sb_t sb[$];
  int checks = 0;
  int errors = 0;
  logic clk = 1'b0;
  logic reset;
  logic [15:0] outs;
  control_sequencer_if bus ();
  control_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign outs = {bus.ir_we, bus.pc_we, bus.uncondbr, bus.br_taken, bus.reg2loc, bus.alusrc,
                 bus.aluop, bus.flag_we, bus.mem_req, bus.mem_we, bus.mem2reg, bus.reg_we,
                 bus.halted, bus.mem_err};
  task automatic check();
    sb_t s;
    s = sb.pop_front();
    checks++;
    assert (outs === s.exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", s.tag, outs, s.exp);
    end
  endtask
  task automatic step(input string tag, input logic [15:0] e);
    sb_t s;
    s.tag = tag;
    s.exp = e;
    sb.push_back(s);
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
  endtask
  task automatic fd(input string t, input logic [31:0] w);
    bus.instr = w;
    step({t, "_fetch"}, IR);
    bus.instr = 32'hDEADBEEF;
    step({t, "_decode"}, 16'h0);
  endtask
  initial begin
    reset = 1'b0;
    bus.instr = '0;
    bus.alu_zero = 1'b0;
    bus.flag_n = 1'b0;
    bus.flag_v = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    step("reset0", 16'h0);
    step("reset1", 16'h0);
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    fd("addi", 32'h91001401);
    step("addi_exec", AS | ADD);
    step("addi_wb", AS | ADD | RW | PC);
    bus.mem_ready = 1'b0;
    fd("subs", 32'hEB020021);
    step("subs_exec", SUB | FW);
    step("subs_wb", SUB | RW | PC);
    bus.flag_n = 1'b1;
    fd("blt", 32'h5400004B);
    step("blt_exec", PC | BT);
    fd("beq", 32'h54000040);
    step("beq_exec", PC);
    bus.flag_n = 1'b0;
    fd("b", 32'h14000003);
    step("b_exec", UB | PC | BT);
    fd("cbz0", 32'hB4000042);
    step("cbz0_exec", R2 | PC);
    bus.alu_zero = 1'b1;
    fd("cbz1", 32'hB4000042);
    step("cbz1_exec", R2 | PC | BT);
    bus.alu_zero = 1'b0;
    fd("ldur", 32'hF8400023);
    step("ldur_exec", AS | ADD);
    for (int i = 0; i < 3; i++) step("ldur_wait", AS | ADD | MR);
    bus.mem_ready = 1'b1;
    step("ldur_ready", AS | ADD | MR);
    bus.mem_ready = 1'b0;
    step("ldur_wb", AS | ADD | M2R | RW | PC);
    fd("stur_late", 32'hF8000023);
    step("stur_late_exec", R2 | AS | ADD);
    for (int i = 0; i < 15; i++) step("stur_late_wait", R2 | AS | ADD | MR | MW);
    bus.mem_ready = 1'b1;
    step("stur_ready_at_limit", R2 | AS | ADD | MR | MW | PC);
    bus.mem_ready = 1'b0;
    fd("stur_to", 32'hF8000023);
    step("stur_to_exec", R2 | AS | ADD);
    for (int i = 0; i < 16; i++) step("stur_to_wait", R2 | AS | ADD | MR | MW);
    step("halt0", HT | ME);
    bus.mem_ready = 1'b1;
    step("halt_ignore_ready", HT | ME);
    step("halt2", HT | ME);
    bus.mem_ready = 1'b0;
    reset = 1'b0;
    step("halt_reset", 16'h0);
    reset = 1'b1;
    fd("ldur_abort", 32'hF8400023);
    step("ldur_abort_exec", AS | ADD);
    step("ldur_abort_wait", AS | ADD | MR);
    reset = 1'b0;
    step("mid_mem_reset", 16'h0);
    reset = 1'b1;
    fd("illegal", 32'h00000000);
`ifdef ILLEGAL_TRAP_EN
    step("illegal_halt", HT);
    step("illegal_stay", HT);
`else
    step("illegal_nop", PC);
    fd("after_nop", 32'h91001401);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
